instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Upstream boot stage for the processor.
- Accepts a byte stream on a valid/ready interface, parses a 4-byte header, and assembles big-endian 32-bit instruction words.
- Drives the processor's init_pc, instr_we and instr_feed ports, and holds the processor in reset until the header is parsed.
- Replaces the hand-driven instruction feed used in simulation with a synthesizable loader, e.g. fed from a UART receiver.

Parameters:
- ADDR_W, 10, width of init_pc and of the word index; maximum program size is 2**ADDR_W words.
- MAX_WORDS, 1024, largest legal header word count. Must be ≤ 2**ADDR_W.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- reload  input  1  one-cycle pulse; restarts a load from DONE or ERR.
- cpu_rst  output  1  reset to the processor's rst port.
- init_pc  output  ADDR_W  start PC taken from the header.
- instr_we  output  1  one-cycle write strobe per word.
- instr_feed  output  32  assembled instruction word.
- word_idx  output  ADDR_W  index of the word currently on instr_feed (0-based).
- load_done  output  1  level; load completed.
- load_err  output  1  level; header count illegal.

Behaviour:
- Handshake: a byte transfers on a rising edge where in_valid && in_ready. in_data is ignored otherwise.
- States:
  - HDR (4 header bytes): bytes 0-1 are word count N[15:0], big-endian; bytes 2-3 are start PC S[15:0], big-endian.
  - LOAD
  - DONE
  - ERR
- Reset values (all take effect in the cycle after a rst edge):
  - state=HDR, byte counter=0, word counter=0.
  - in_ready=1, cpu_rst=1, init_pc=0, instr_we=0, instr_feed=0, word_idx=0, load_done=0, load_err=0.
- HDR:
  - in_ready=1, cpu_rst=1.
  - On acceptance of header byte 3:
    - init_pc <= S[ADDR_W-1:0]; upper bits of S are ignored.
    - If N > MAX_WORDS, go to ERR.
    - Else if N == 0, go to DONE.
    - Else go to LOAD.
  - cpu_rst=0 from the first cycle in LOAD or DONE.
- LOAD:
  - in_ready=1 and cpu_rst=0.
  - The first byte of each word lands in instr_feed[31:24], the fourth in [7:0].
  - On the edge accepting the 4th byte of word k:
    - instr_feed <= assembled word, word_idx <= k, registered.
    - instr_we=1 for exactly the following cycle.
    - instr_feed and word_idx hold until the next word completes.
  - Back-to-back words are possible: minimum 4 cycles between instr_we pulses.
  - After the 4th byte of word N-1 is accepted, state=DONE; the final instr_we pulse occurs in the first DONE cycle.
- DONE:
  - in_ready=0, load_done=1, cpu_rst=0.
  - Stays until reload or rst.
- ERR:
  - in_ready=0, load_err=1, cpu_rst=1 (the processor never runs).
  - Stays until reload or rst.
- reload in DONE or ERR:
  - Next cycle: state=HDR, counters=0, cpu_rst=1, load_done=0, load_err=0.
  - init_pc and instr_feed hold their values.
  - reload is ignored in HDR and LOAD.
- rst has priority over reload and over an in-flight transfer. A mid-load rst discards the partial word, and no instr_we is issued for it.
- Word counter width is ADDR_W+1 so that N=MAX_WORDS=1024 terminates correctly.
- in_valid may deassert between any bytes. State is held, with no timeout.

Decomposition:
- Shared package proc_pkg:
  - State encoding: HDR=2'd0, LOAD=2'd1, DONE=2'd2, ERR=2'd3.
  - HDR_BYTES=4.
  - INSTR_W=32.
- One natural sub-module, byte_packer: a 4-byte big-endian shift/assemble unit with a 2-bit byte counter and a word_valid pulse. Reused for the header fields and for data words.
- The top level holds the FSM, word counter and output registers.

Test Plan:
- Nominal load: stream 00 03 00 05, then 3 words 20080001, 20090002, 01095020, all with in_valid held high → exactly 3 instr_we pulses, each 4 cycles apart, with word_idx 0,1,2 and matching instr_feed. init_pc=5 and cpu_rst=0 from the cycle after header byte 3; load_done=1 with in_ready=0 after the last pulse.
- Gapped input: same stream with in_valid toggling 1/0 every cycle → identical words and indices; instr_we pulses 8 cycles apart.
- Zero count: header 00 00 01 FF → no instr_we; init_pc=10'h1FF, load_done=1, cpu_rst=0. A further in_valid byte is not accepted.
- Illegal count: header 04 01 00 00 (N=1025) → ERR: load_err=1, cpu_rst stays 1, in_ready=0. A reload pulse then returns to HDR with load_err=0; a following valid 1-word load completes.
- Mid-load reset: N=2, assert rst after the 6th data byte → no second instr_we. After reset, all outputs are at reset values and cpu_rst=1; a new header is accepted from byte 0.
- Max size: N=1024, with the word value equal to its index → 1024 pulses, last word_idx=1023, then load_done=1 with no counter wrap.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding and
// the framing constants used by the byte packer and the top level.
package proc_pkg;

    // Number of bytes in the header and in each instruction word.
    localparam int HDR_BYTES = 4;

    // Width of an assembled instruction word.
    localparam int INSTR_W = 32;

    // Loader FSM states.
    typedef enum logic [1:0] {
        HDR  = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } load_state_e;

endpackage

// File: rtl/instr_loader_packer.sv
// byte_packer: collects four stream bytes into one big-endian 32-bit word.
// The first byte ends up in bits [31:24] and the fourth byte in bits [7:0].
// word_valid_o is a combinational strobe that is high on the cycle the fourth
// byte transfers; word_o is valid only while that strobe is high.
// The same unit frames both the header and the data words.
module byte_packer
    import proc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               fire_i,
    input  logic [7:0]         byte_i,
    output logic [INSTR_W-1:0] word_o,
    output logic               word_valid_o
);

    logic [INSTR_W-9:0] shift_q, shift_d;
    logic [1:0]         cnt_q, cnt_d;

    // The word is the three stored bytes followed by the byte arriving now.
    assign word_o       = {shift_q, byte_i};
    assign word_valid_o = fire_i && (cnt_q == 2'(HDR_BYTES - 1));

    // Shift in accepted bytes; the 2-bit counter wraps back to 0 after byte 3.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            cnt_d = 2'd0;
        end else if (fire_i) begin
            shift_d = word_o[INSTR_W-9:0];
            cnt_d   = cnt_q + 2'd1;
        end
    end

    // Register the partial word and the byte position.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= 2'd0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: boot-time loader that parses a 4-byte header (word count,
// start PC) from a byte stream and then feeds big-endian instruction words
// to the processor, holding the processor in reset until the header is in.
//
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready;
// in_data is ignored on every other edge, and in_valid may drop between any
// two bytes without losing state.
module instr_loader
    import proc_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    input  logic               reload,
    output logic               cpu_rst,
    output logic [ADDR_W-1:0]  init_pc,
    output logic               instr_we,
    output logic [INSTR_W-1:0] instr_feed,
    output logic [ADDR_W-1:0]  word_idx,
    output logic               load_done,
    output logic               load_err,
    output logic [1:0]         state_dbg
);

    load_state_e        state_q, state_d;
    // One bit wider than the index so a count of 2**ADDR_W can be reached.
    logic [ADDR_W:0]    word_cnt_q, word_cnt_d;
    logic [ADDR_W:0]    n_q, n_d;
    logic [ADDR_W-1:0]  init_pc_q, init_pc_d;
    logic               instr_we_q, instr_we_d;
    logic [INSTR_W-1:0] instr_feed_q, instr_feed_d;
    logic [ADDR_W-1:0]  word_idx_q, word_idx_d;

    logic               fire;
    logic               reload_take;
    logic [INSTR_W-1:0] pack_word;
    logic               pack_valid;
    logic [15:0]        hdr_n;
    logic [ADDR_W:0]    word_cnt_inc;

    assign fire         = in_valid && in_ready;
    assign hdr_n        = pack_word[31:16];
    assign word_cnt_inc = word_cnt_q + 1'b1;

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (reload_take),
        .fire_i       (fire),
        .byte_i       (in_data),
        .word_o       (pack_word),
        .word_valid_o (pack_valid)
    );

    // Level outputs decoded from the current state.
    always_comb begin
        in_ready  = (state_q == HDR) || (state_q == LOAD);
        cpu_rst   = (state_q == HDR) || (state_q == ERR);
        load_done = (state_q == DONE);
        load_err  = (state_q == ERR);
    end

    // Next-state logic: header parse, word delivery, and reload handling.
    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        n_d          = n_q;
        init_pc_d    = init_pc_q;
        instr_we_d   = 1'b0;
        instr_feed_d = instr_feed_q;
        word_idx_d   = word_idx_q;
        reload_take  = 1'b0;
        case (state_q)
            HDR: begin
                if (pack_valid) begin
                    init_pc_d  = pack_word[ADDR_W-1:0];
                    n_d        = pack_word[16+ADDR_W:16];
                    word_cnt_d = '0;
                    if ({16'd0, hdr_n} > 32'(MAX_WORDS)) begin
                        state_d = ERR;
                    end else if (hdr_n == 16'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (pack_valid) begin
                    instr_we_d   = 1'b1;
                    instr_feed_d = pack_word;
                    word_idx_d   = word_cnt_q[ADDR_W-1:0];
                    word_cnt_d   = word_cnt_inc;
                    if (word_cnt_inc == n_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE, ERR: begin
                if (reload) begin
                    state_d     = HDR;
                    word_cnt_d  = '0;
                    reload_take = 1'b1;
                end
            end
            default: begin
                state_d = HDR;
            end
        endcase
    end

    // State and output registers; rst wins over reload and any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HDR;
            word_cnt_q   <= '0;
            n_q          <= '0;
            init_pc_q    <= '0;
            instr_we_q   <= 1'b0;
            instr_feed_q <= '0;
            word_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            n_q          <= n_d;
            init_pc_q    <= init_pc_d;
            instr_we_q   <= instr_we_d;
            instr_feed_q <= instr_feed_d;
            word_idx_q   <= word_idx_d;
        end
    end

    assign init_pc    = init_pc_q;
    assign instr_we   = instr_we_q;
    assign instr_feed = instr_feed_q;
    assign word_idx   = word_idx_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed plus randomized bench for instr_loader. A reference model built
// from the load rules (header -> expected init_pc, ordered list of expected
// word writes) is compared against the processor-side outputs.
module tb_instr_loader;

  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1024;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              reload;
  logic              cpu_rst;
  logic [ADDR_W-1:0] init_pc;
  logic              instr_we;
  logic [31:0]       instr_feed;
  logic [ADDR_W-1:0] word_idx;
  logic              load_done;
  logic              load_err;
  logic [1:0]        state_dbg;

  // Clock / reset block
  always #5 clk = ~clk;

  instr_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .reload     (reload),
    .cpu_rst    (cpu_rst),
    .init_pc    (init_pc),
    .instr_we   (instr_we),
    .instr_feed (instr_feed),
    .word_idx   (word_idx),
    .load_done  (load_done),
    .load_err   (load_err),
    .state_dbg  (state_dbg)
  );

  // Scoreboard state
  int                 n_checks = 0;
  int                 n_fail = 0;
  int                 cyc = 0;
  logic [ADDR_W+31:0] exp_q[$];
  logic [31:0]        data_q[$];
  int                 exp_gap = 0;
  int                 last_we_cyc = 0;
  bit                 last_we_valid = 1'b0;
  int                 we_count = 0;
  logic [ADDR_W-1:0]  m_init_pc = '0;
  logic [31:0]        m_feed = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every write strobe must match the next expected write.
  always @(negedge clk) begin : we_monitor
    logic [ADDR_W+31:0] e;
    if (instr_we === 1'b1) begin
      we_count++;
      if (exp_q.size() == 0) begin
        chk("we_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("we_idx", 64'(word_idx), 64'(e[ADDR_W+31:32]));
        chk("we_word", 64'(instr_feed), 64'(e[31:0]));
      end
      if (last_we_valid) begin
        chk("we_spacing_ge4", 64'((cyc - last_we_cyc) >= 4), 64'd1);
        if (exp_gap != 0) chk("we_gap", 64'(cyc - last_we_cyc), 64'(exp_gap));
      end
      last_we_cyc   = cyc;
      last_we_valid = 1'b1;
    end
  end

  // Driver: present one byte and hold it until it transfers.
  task automatic send_byte(input logic [7:0] b, input int mode);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = b;
    if (mode == 2) reload = 1'($urandom_range(0, 1));
    while (in_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 50) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    reload   = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Idle cycles between bytes: none, exactly one, or a random 0..2.
  task automatic idle(input int mode);
    int k;
    k = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
    repeat (k) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_hdr(input logic [15:0] n16, input logic [15:0] s16, input int mode);
    send_byte(n16[15:8], mode); idle(mode);
    send_byte(n16[7:0], mode);  idle(mode);
    send_byte(s16[15:8], mode); idle(mode);
    send_byte(s16[7:0], mode);
  endtask

  // Full load: header, then data_q words; model derives all expectations.
  task automatic run_load(input int n, input logic [15:0] s16, input int mode, input int gap_exp);
    logic [31:0] w;
    last_we_valid = 1'b0;
    exp_gap       = gap_exp;
    we_count      = 0;
    chk("start_in_hdr", 64'(state_dbg), 64'd0);
    chk("start_cpu_rst", 64'(cpu_rst), 64'd1);
    send_hdr(16'(n), s16, mode);
    m_init_pc = s16[ADDR_W-1:0];
    chk("init_pc", 64'(init_pc), 64'(m_init_pc));
    if (n > MAX_WORDS) begin
      chk("err_load_err", 64'(load_err), 64'd1);
      chk("err_cpu_rst", 64'(cpu_rst), 64'd1);
      chk("err_in_ready", 64'(in_ready), 64'd0);
      chk("err_load_done", 64'(load_done), 64'd0);
      idle(mode);
      return;
    end
    chk("hdr_cpu_rst_low", 64'(cpu_rst), 64'd0);
    if (n == 0) begin
      chk("zero_load_done", 64'(load_done), 64'd1);
      chk("zero_in_ready", 64'(in_ready), 64'd0);
      chk("zero_load_err", 64'(load_err), 64'd0);
      idle(mode);
      return;
    end
    chk("load_in_ready", 64'(in_ready), 64'd1);
    chk("load_not_done", 64'(load_done), 64'd0);
    for (int k = 0; k < n; k++) exp_q.push_back({ADDR_W'(k), data_q[k]});
    idle(mode);
    for (int k = 0; k < n; k++) begin
      w = data_q[k];
      for (int b = 0; b < 4; b++) begin
        send_byte(w[31-8*b -: 8], mode);
        if (!(k == n - 1 && b == 3)) idle(mode);
      end
    end
    chk("end_load_done", 64'(load_done), 64'd1);
    chk("end_in_ready", 64'(in_ready), 64'd0);
    chk("end_cpu_rst", 64'(cpu_rst), 64'd0);
    chk("end_final_we", 64'(instr_we), 64'd1);
    @(posedge clk); #1;
    m_feed = data_q[n-1];
    chk("end_we_low", 64'(instr_we), 64'd0);
    chk("end_exp_empty", 64'(exp_q.size()), 64'd0);
    chk("end_we_count", 64'(we_count), 64'(n));
    chk("end_word_idx", 64'(word_idx), 64'(n - 1));
    chk("end_instr_feed", 64'(instr_feed), 64'(m_feed));
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    chk("reload_state_hdr", 64'(state_dbg), 64'd0);
    chk("reload_done_low", 64'(load_done), 64'd0);
    chk("reload_err_low", 64'(load_err), 64'd0);
    chk("reload_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("reload_in_ready", 64'(in_ready), 64'd1);
    chk("reload_init_pc_hold", 64'(init_pc), 64'(m_init_pc));
    chk("reload_feed_hold", 64'(instr_feed), 64'(m_feed));
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("rst_init_pc", 64'(init_pc), 64'd0);
    chk("rst_instr_we", 64'(instr_we), 64'd0);
    chk("rst_instr_feed", 64'(instr_feed), 64'd0);
    chk("rst_word_idx", 64'(word_idx), 64'd0);
    chk("rst_load_done", 64'(load_done), 64'd0);
    chk("rst_load_err", 64'(load_err), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m_init_pc = '0; m_feed = '0;
    chk_reset_vals();

    // Nominal load, valid held high.
    data_q = '{32'h20080001, 32'h20090002, 32'h01095020};
    run_load(3, 16'h0005, 0, 4);
    do_reload();

    // Same stream with in_valid toggling every cycle.
    run_load(3, 16'h0005, 1, 8);
    do_reload();

    // Zero count; further bytes are refused.
    run_load(0, 16'h01FF, 0, 0);
    in_valid = 1'b1; in_data = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("zero_refuse_ready", 64'(in_ready), 64'd0);
      chk("zero_stays_done", 64'(load_done), 64'd1);
    end
    in_valid = 1'b0;
    do_reload();

    // Illegal count 1025, then reload and a good 1-word load.
    run_load(1025, 16'h0000, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("err_sticky", 64'(load_err), 64'd1);
    chk("err_cpu_rst_sticky", 64'(cpu_rst), 64'd1);
    do_reload();
    data_q = '{32'hDEADBEEF};
    run_load(1, 16'h0123, 0, 4);
    do_reload();

    // Mid-load reset after 6 data bytes of a 2-word load.
    data_q = '{32'h11223344, 32'h55667788};
    last_we_valid = 1'b0; exp_gap = 0; we_count = 0;
    exp_q.push_back({ADDR_W'(0), data_q[0]});
    send_hdr(16'd2, 16'h0007, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h55, 0); send_byte(8'h66, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_init_pc = '0; m_feed = '0;
    chk_reset_vals();
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_we_count", 64'(we_count), 64'd1);
    chk("midrst_exp_empty", 64'(exp_q.size()), 64'd0);
    data_q = '{32'hCAFEF00D};
    run_load(1, 16'h0003, 2, 0);

    // Randomized loads with random gaps and ignored reload pulses.
    for (int it = 0; it < 4; it++) begin
      int n;
      do_reload();
      n = int'($urandom_range(1, 8));
      data_q.delete();
      for (int k = 0; k < n; k++) data_q.push_back($urandom);
      run_load(n, 16'($urandom), 2, 0);
    end

    // Maximum size: 1024 words, value equal to index.
    do_reload();
    data_q.delete();
    for (int k = 0; k < MAX_WORDS; k++) data_q.push_back(32'(k));
    run_load(MAX_WORDS, 16'hFFFF, 0, 4);
    repeat (3) @(posedge clk);
    #1;
    chk("max_still_done", 64'(load_done), 64'd1);
    chk("max_no_wrap_idx", 64'(word_idx), 64'd1023);
    chk("max_we_total", 64'(we_count), 64'd1024);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
